button_pulser: RTL and testbench
================================

# button_pulser

Conditions the five raw push-buttons for the game core. It synchronises each button to board_clk and debounces it into a stable level. It emits single-cycle press pulses on the BtnC_Pulse/BtnL_Pulse/BtnD_Pulse/BtnR_Pulse/BtnU_Pulse nets. It also generates optional hold-to-repeat pulses for the flight buttons. The block sits between the board pins and the consumers of those nets: flight_control, obstacle_logic, coin_logic and X_RAM_NOREAD.

## Interface
Parameters:
- N_BTN, 5, number of button channels.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable synced samples required before the level changes (10 ms at 100 MHz); must be ≥ 1.
- REPEAT_EN, 5'b01100, per-channel auto-repeat enable (BtnU, BtnD).
- REPEAT_DELAY, 30_000_000, cycles from a press pulse to the first repeat pulse; must be ≥ 1.
- REPEAT_PERIOD, 10_000_000, cycles between subsequent repeat pulses; must be ≥ 1.

Ports:
- board_clk  in  1  system clock (100 MHz).
- Reset  in  1  asynchronous, active-high reset.
- btn_raw  in  N_BTN  raw pins, unsynchronised; bit order [4]=BtnL, [3]=BtnU, [2]=BtnD, [1]=BtnR, [0]=BtnC.
- btn_level  out  N_BTN  debounced level, 1 = held.
- btn_pulse  out  N_BTN  one-cycle pulse on each debounced press and on each repeat.
- btn_release  out  N_BTN  one-cycle pulse on each debounced release.

## Operation
- Channels are fully independent; there is no cross-channel priority.
- Sync stage: a 2-flop synchroniser per bit, reset to 0.
- Debounce counter (width $clog2(DEBOUNCE_CYCLES+1)):
  - Cleared whenever synced == btn_level.
  - Incremented while synced != btn_level.
  - When it reaches DEBOUNCE_CYCLES-1 with synced != level, the next edge toggles btn_level and clears the counter.
- Any glitch shorter than DEBOUNCE_CYCLES cycles is fully rejected, with no output activity.
- Channel FSM states: RELEASED, HELD, REPEATING.
  - RELEASED→HELD on the debounced rise: btn_pulse=1 for that one cycle; repeat counter cleared.
  - HELD: repeat counter increments only if REPEAT_EN[i]=1. At REPEAT_DELAY-1 the next edge pulses, clears the counter and moves to REPEATING. With REPEAT_EN[i]=0 the FSM stays in HELD.
  - REPEATING: at REPEAT_PERIOD-1 the next edge pulses and clears the counter.
  - HELD/REPEATING→RELEASED on the debounced fall: btn_release=1 for one cycle, repeat counter cleared. A repeat coinciding with the fall is suppressed; release wins.
- Repeat counter width: $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1); it never wraps.
- btn_pulse and btn_release are never asserted together on one channel.

## Timing
- Reset values: btn_level=0, btn_pulse=0, btn_release=0; all counters 0; FSMs in RELEASED; synchronisers 0.
- Reset is asynchronous assert; deassertion is synchronised externally.
- All outputs are registered.
- Press latency: raw rises before edge k and stays stable → synced high at edge k+2 → btn_level=1 and btn_pulse=1 after edge k+1+DEBOUNCE_CYCLES, held for exactly one cycle.
- Release latency: identical, on btn_level fall and btn_release.
- First repeat: REPEAT_DELAY cycles after the press pulse.
- Subsequent repeats: every REPEAT_PERIOD cycles.
- Reset mid-hold: everything clears. A button still held re-debounces from scratch and emits a fresh press pulse DEBOUNCE_CYCLES+1 cycles after the first post-reset edge.
- BtnR is debounced like the others. The top level still drives Reset from the raw pin, so btn_pulse[1] is informational only.

## Structure
- game_pkg holds:
  - Index constants BTN_C=0, BTN_R=1, BTN_D=2, BTN_U=3, BTN_L=4.
  - N_BTN=5.
  - Default DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD.
  - State enum {RELEASED, HELD, REPEATING}.
- Sub-module debounce_channel: one channel (synchroniser, debounce counter, FSM, repeat counter) with a scalar REPEAT_EN. button_pulser instantiates N_BTN of them in a generate loop.

## Test plan
Bench overrides: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, REPEAT_EN=5'b01100.
- Clean press/release: btn_raw[0] 0→1 for 20 cycles, then 0 → one btn_pulse[0] 5 cycles after the rise sample; btn_level[0] high 20 cycles; one btn_release[0] 5 cycles after the fall; no repeats.
- Bounce rejection: btn_raw[4] toggles every 2 cycles for 16 cycles, then settles at 1 → no output during bounce; exactly one btn_pulse[4], 5 cycles after settling.
- Auto-repeat: hold btn_raw[3] for 40 cycles → pulses at press P, P+10, P+15, P+20, P+25, P+30, P+35 (seven total); btn_release[3] once; btn_raw[4] held alike → single pulse only.
- Release/repeat collision: time the btn_raw[2] release so the debounced fall lands on a repeat cycle → btn_release[2]=1, btn_pulse[2]=0 that cycle.
- Reset mid-hold: assert Reset at P+12 while btn_raw[3] is held, deassert 3 cycles later → outputs 0 immediately; fresh btn_pulse[3] 5 cycles after the first post-reset edge.
- Simultaneous presses: all five bits rise together → all five btn_pulse bits assert on the same cycle; levels identical.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared button indices, default timing and channel state type for the game core.
package game_pkg;
    localparam int BTN_C = 0;
    localparam int BTN_R = 1;
    localparam int BTN_D = 2;
    localparam int BTN_U = 3;
    localparam int BTN_L = 4;
    localparam int N_BTN = 5;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY = 30_000_000;
    localparam int DEF_REPEAT_PERIOD = 10_000_000;
    localparam logic [N_BTN-1:0] DEF_REPEAT_EN = 5'b01100;
    typedef enum logic [1:0] {RELEASED, HELD, REPEATING} btn_state_t;
    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one button: synchroniser, debounce counter, press/repeat/release FSM.
module debounce_channel import game_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit REPEAT_EN = 1'b0,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic board_clk,
    input  logic Reset,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    logic [1:0] sync;
    logic [DW-1:0] db_cnt;
    logic [RW-1:0] rpt_cnt, rpt_cnt_next;
    btn_state_t state, state_next;
    logic synced, settle, rise, fall, repeat_due, pulse_next, release_next;

    assign synced = sync[1];
    // settle marks the edge on which the debounced level flips
    assign settle = synced != level && db_cnt == DW'(DEBOUNCE_CYCLES - 1);
    assign rise = settle && synced;
    assign fall = settle && !synced;
    assign repeat_due = REPEAT_EN && rpt_cnt == (state == HELD ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1));

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            sync <= '0;
            db_cnt <= '0;
            level <= 1'b0;
            state <= RELEASED;
            rpt_cnt <= '0;
            press_pulse <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            db_cnt <= (synced == level || settle) ? '0 : db_cnt + 1'b1;
            level <= level ^ settle;
            state <= state_next;
            rpt_cnt <= rpt_cnt_next;
            press_pulse <= pulse_next;
            release_pulse <= release_next;
        end
    end

    // release takes precedence over a repeat landing on the same edge
    always_comb begin
        state_next = state;
        rpt_cnt_next = '0;
        pulse_next = 1'b0;
        release_next = 1'b0;
        if (state == RELEASED) begin
            if (rise) begin
                state_next = HELD;
                pulse_next = 1'b1;
            end
        end else if (fall) begin
            state_next = RELEASED;
            release_next = 1'b1;
        end else if (repeat_due) begin
            state_next = REPEATING;
            pulse_next = 1'b1;
        end else if (REPEAT_EN) begin
            rpt_cnt_next = rpt_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/button_pulser.sv
// button_pulser: conditions the raw push-buttons into debounced levels, press/repeat pulses and release pulses.
module button_pulser #(
    parameter int N_BTN = game_pkg::N_BTN,
    parameter int DEBOUNCE_CYCLES = game_pkg::DEF_DEBOUNCE_CYCLES,
    parameter logic [N_BTN-1:0] REPEAT_EN = game_pkg::DEF_REPEAT_EN,
    parameter int REPEAT_DELAY = game_pkg::DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = game_pkg::DEF_REPEAT_PERIOD
) (
    input  logic             board_clk,
    input  logic             Reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [N_BTN-1:0] btn_release
);
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_EN(REPEAT_EN[i]),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .board_clk(board_clk),
            .Reset(Reset),
            .raw(btn_raw[i]),
            .level(btn_level[i]),
            .press_pulse(btn_pulse[i]),
            .release_pulse(btn_release[i])
        );
    end
endmodule

// File: tb/tb_button_pulser.sv
// tb_button_pulser: scoreboard bench; expected pulse/release events are queued by cycle as stimulus is driven.
module tb_button_pulser;
    localparam int DEB = 4;
    localparam int LAT = DEB + 2;

    typedef struct {
        int at;
        logic [4:0] p;
        logic [4:0] r;
    } ev_t;

    logic board_clk = 1'b0;
    logic Reset;
    logic [4:0] btn_raw;
    logic [4:0] btn_level, btn_pulse, btn_release;
    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int c, p;
    ev_t q[$];
    ev_t e;

    button_pulser #(
        .N_BTN(5),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_EN(5'b01100),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(5)
    ) dut (
        .board_clk(board_clk),
        .Reset(Reset),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse),
        .btn_release(btn_release)
    );

    always #5 board_clk = ~board_clk;
    always @(posedge board_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, want %0h", tag, cyc, got, exp);
    endtask

    task automatic expect_ev(input int at, input logic [4:0] pm, input logic [4:0] rm);
        ev_t x;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].at == at) begin
                x = q[i];
                x.p |= pm;
                x.r |= rm;
                q[i] = x;
                return;
            end
            if (q[i].at > at) begin
                x.at = at;
                x.p = pm;
                x.r = rm;
                q.insert(i, x);
                return;
            end
        end
        x.at = at;
        x.p = pm;
        x.r = rm;
        q.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge board_clk);
    endtask

    always begin
        @(posedge board_clk);
        #1;
        while (q.size() != 0 && q[0].at < cyc) begin
            check("missed_event", 32'(cyc), 32'(q[0].at));
            void'(q.pop_front());
        end
        if (q.size() != 0 && q[0].at == cyc) begin
            e = q.pop_front();
            check("pulse", 32'(btn_pulse), 32'(e.p));
            check("release", 32'(btn_release), 32'(e.r));
        end else if ((btn_pulse | btn_release) != 5'b0) begin
            check("spurious", 32'({btn_pulse, btn_release}), 0);
        end
    end

    initial begin
        Reset = 1'b1;
        btn_raw = 5'b0;
        idle(3);
        check("rst_level", 32'(btn_level), 0);
        check("rst_pulse", 32'(btn_pulse), 0);
        check("rst_release", 32'(btn_release), 0);
        Reset = 1'b0;
        idle(5);

        btn_raw[0] = 1'b1;
        c = cyc;
        expect_ev(c + LAT, 5'b00001, 5'b0);
        idle(5);
        check("clean_level_pre", 32'(btn_level), 0);
        idle(1);
        check("clean_level_on", 32'(btn_level), 32'h01);
        idle(14);
        btn_raw[0] = 1'b0;
        expect_ev(cyc + LAT, 5'b0, 5'b00001);
        idle(5);
        check("clean_level_hold", 32'(btn_level), 32'h01);
        idle(1);
        check("clean_level_off", 32'(btn_level), 0);
        idle(10);

        for (int k = 0; k < 8; k++) begin
            btn_raw[4] = (k % 2 == 0);
            idle(2);
        end
        check("bounce_level", 32'(btn_level), 0);
        btn_raw[4] = 1'b1;
        expect_ev(cyc + LAT, 5'b10000, 5'b0);
        idle(10);
        check("bounce_level_on", 32'(btn_level), 32'h10);
        btn_raw[4] = 1'b0;
        expect_ev(cyc + LAT, 5'b0, 5'b10000);
        idle(12);

        btn_raw = 5'b11000;
        p = cyc + LAT;
        expect_ev(p, 5'b11000, 5'b0);
        for (int k = 2; k <= 7; k++) expect_ev(p + 5 * k, 5'b01000, 5'b0);
        idle(20);
        check("repeat_level", 32'(btn_level), 32'h18);
        idle(20);
        btn_raw = 5'b0;
        expect_ev(cyc + LAT, 5'b0, 5'b11000);
        idle(12);

        btn_raw[2] = 1'b1;
        p = cyc + LAT;
        expect_ev(p, 5'b00100, 5'b0);
        expect_ev(p + 10, 5'b00100, 5'b0);
        idle(15);
        btn_raw[2] = 1'b0;
        expect_ev(cyc + LAT, 5'b0, 5'b00100);
        idle(12);

        btn_raw[3] = 1'b1;
        p = cyc + LAT;
        expect_ev(p, 5'b01000, 5'b0);
        expect_ev(p + 10, 5'b01000, 5'b0);
        idle(18);
        Reset = 1'b1;
        #1;
        check("midrst_level", 32'(btn_level), 0);
        check("midrst_pulse", 32'(btn_pulse), 0);
        q.delete();
        idle(3);
        Reset = 1'b0;
        expect_ev(cyc + LAT, 5'b01000, 5'b0);
        idle(6);
        check("midrst_relevel", 32'(btn_level), 32'h08);
        idle(2);
        btn_raw[3] = 1'b0;
        expect_ev(cyc + LAT, 5'b0, 5'b01000);
        idle(12);

        btn_raw = 5'b11111;
        expect_ev(cyc + LAT, 5'b11111, 5'b0);
        idle(6);
        check("all_level", 32'(btn_level), 32'h1f);
        idle(2);
        btn_raw = 5'b0;
        expect_ev(cyc + LAT, 5'b0, 5'b11111);
        idle(12);
        check("all_level_off", 32'(btn_level), 0);
        check("drain", 32'(q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
